// File: rtl/counter_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// counter_sweep_ctrl
//
// Sweep sequencer for a CounterUpDown instance. After an accepted start the
// counter is loaded with a start value, ramped up to an upper limit and then
// down to a lower limit. That up/down pair repeats for a programmed number of
// sweeps, or indefinitely when the sweep count is zero. This block is the only
// driver of the counter's IN/load/UP/Down inputs, and it watches the counter
// value to decide when to turn.
//
// Ports
//   CLK, RST      clock (rising edge) and asynchronous active-low reset
//   start         run request, sampled only while idle
//   abort         abandon the run and return to idle (highest priority)
//   pause         freeze the ramp; no counter commands while high
//   start_val     counter load value          (latched at start)
//   hi_lim        upper turn point            (latched at start)
//   lo_lim        lower turn point            (latched at start)
//   n_sweeps      number of sweeps, 0 = endless (latched at start)
//   cnt_val       current counter value
//   IN            counter load value (the latched start value)
//   load/UP/Down  counter commands; at most one is high in any cycle
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse when the programmed sweeps complete
//   err           one-cycle pulse after a rejected start
//   sweep_cnt     sweeps completed in the current or last run
// ---------------------------------------------------------------------------
module counter_sweep_ctrl #(
    parameter int WIDTH = 5,
    parameter int NSW_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] hi_lim,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [NSW_W-1:0] n_sweeps,
    input  logic [WIDTH-1:0] cnt_val,
    output logic [WIDTH-1:0] IN,
    output logic             load,
    output logic             UP,
    output logic             Down,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NSW_W-1:0] sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RAMP_UP = 3'd2,
        S_RAMP_DN = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] start_q,     start_d;
    logic [WIDTH-1:0] hi_q,        hi_d;
    logic [WIDTH-1:0] lo_q,        lo_d;
    logic [NSW_W-1:0] nsw_q,       nsw_d;
    logic [NSW_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic             done_q,      done_d;
    logic             err_q,       err_d;

    // Configuration check on the live inputs: a strictly non-empty range
    // that contains the start value.
    logic cfg_ok;
    assign cfg_ok = (lo_lim < hi_lim) &&
                    (lo_lim <= start_val) &&
                    (start_val <= hi_lim);

    // Turn-point detection always uses the latched limits, so inputs
    // changed mid-run have no effect.
    logic at_hi;
    logic at_lo;
    assign at_hi = (cnt_val == hi_q);
    assign at_lo = (cnt_val == lo_q);

    // Sweep counter wraps modulo 2^NSW_W; the completion test compares the
    // wrapped value, so an endless run (n_sweeps == 0) is excluded explicitly.
    logic [NSW_W-1:0] sweep_inc;
    logic             last_sweep;
    assign sweep_inc  = sweep_cnt_q + NSW_W'(1);
    assign last_sweep = (nsw_q != '0) && (sweep_inc == nsw_q);

    // -----------------------------------------------------------------------
    // Next-state and register-update logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        nsw_d       = nsw_q;
        sweep_cnt_d = sweep_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        start_d     = start_val;
                        hi_d        = hi_lim;
                        lo_d        = lo_lim;
                        nsw_d       = n_sweeps;
                        sweep_cnt_d = '0;
                        state_d     = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            // pause is ignored here: the load always completes in one cycle.
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RAMP_UP;
                end
            end

            S_RAMP_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause && at_hi) begin
                    state_d = S_RAMP_DN;
                end
            end

            S_RAMP_DN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause && at_lo) begin
                    sweep_cnt_d = sweep_inc;
                    if (last_sweep) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RAMP_UP;
                    end
                end
            end

            // One-cycle completion state; a start seen here is not sampled.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            start_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            nsw_q       <= '0;
            sweep_cnt_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            nsw_q       <= nsw_d;
            sweep_cnt_q <= sweep_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Commands are decoded from distinct states, so they are mutually
    // exclusive by construction. Stopping at the limit (rather than one past
    // it) keeps the counter from ever stepping beyond hi or below lo.
    assign load = (state_q == S_LOAD);
    assign UP   = (state_q == S_RAMP_UP) && !pause && !at_hi;
    assign Down = (state_q == S_RAMP_DN) && !pause && !at_lo;

    assign IN        = start_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign sweep_cnt = sweep_cnt_q;

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sweep sequencer for the 5-bit up/down counter. It drives the counter's `IN`, `load`, `UP` and `Down` inputs and reads back its value, so the counter ramps from a programmed start value up to an upper limit, then down to a lower limit, for a programmed number of sweeps. It sits between a host-side start/abort handshake and one `CounterUpDown` instance, and is the only block that drives that counter.

## Interface
Parameters:
- `WIDTH`, 5: counter width; all value ports use it.
- `NSW_W`, 4: width of the sweep-count ports.

Ports (clock and reset first):
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a run; sampled only in IDLE.
- `abort`  in  1  abandon the run; return to IDLE.
- `pause`  in  1  freeze the sweep; no counter commands while high.
- `start_val`  in  WIDTH  value loaded into the counter.
- `hi_lim`  in  WIDTH  upper turn point.
- `lo_lim`  in  WIDTH  lower turn point.
- `n_sweeps`  in  NSW_W  number of up+down sweeps; 0 = run until abort.
- `cnt_val`  in  WIDTH  counter's current value.
- `IN`  out  WIDTH  load value to the counter; equals the latched `start_val`.
- `load`  out  1  counter load command.
- `UP`  out  1  counter increment command.
- `Down`  out  1  counter decrement command.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse when the programmed sweeps complete.
- `err`  out  1  one-cycle pulse when a `start` is rejected.
- `sweep_cnt`  out  NSW_W  sweeps completed in the current run.

## Operation
- States: IDLE, LOAD, RAMP_UP, RAMP_DN, DONE.
- IDLE with `start`=1: validate the configuration, requiring `lo_lim < hi_lim` and `lo_lim <= start_val <= hi_lim`.
  - Valid: latch `start_val`, `hi_lim`, `lo_lim` and `n_sweeps`; clear `sweep_cnt`; go to LOAD.
  - Invalid: pulse `err` next cycle and stay in IDLE.
- Inputs changed mid-run are ignored; only the latched copies are used.
- LOAD: `load`=1 for exactly one cycle; next state is RAMP_UP.
- RAMP_UP: `UP` = (`cnt_val` != hi). When `cnt_val` == hi, go to RAMP_DN.
- RAMP_DN: `Down` = (`cnt_val` != lo). When `cnt_val` == lo:
  - increment `sweep_cnt` (wraps modulo 2^NSW_W);
  - if `n_sweeps` != 0 and `sweep_cnt`+1 == `n_sweeps`, go to DONE; else go to RAMP_UP.
- DONE: `done`=1 for one cycle, then IDLE. `sweep_cnt` holds its final value until the next accepted start.
- `load`, `UP` and `Down` are combinational from state, `cnt_val` and `pause`. They are mutually exclusive, so at most one is high in any cycle.
- `pause`=1 in RAMP_UP or RAMP_DN: `UP`=`Down`=0 and the state holds. In LOAD, `pause` is ignored.
- `abort`=1 in any non-IDLE state: go to IDLE at the next edge. No `done`; `sweep_cnt` holds.
  - Priority: `abort` > `pause` > normal transitions.
- Reset (asynchronous, any time, including mid-run):
  - state IDLE, `sweep_cnt`=0, latched registers 0;
  - `done`=0, `err`=0, `busy`=0, `IN`=0, `load`=`UP`=`Down`=0.
- `cnt_val` is don't-care outside RAMP_UP and RAMP_DN. The counter itself has no reset; LOAD initialises it.

## Timing
- Start accepted at edge E0: LOAD during cycle 1, so the counter holds `start_val` from edge E2.
- RAMP_UP: (hi − start_val) cycles with `UP`=1, plus one turn cycle with `UP`=0.
- RAMP_DN: (hi − lo) cycles with `Down`=1, plus one turn cycle.
- Later up-ramps take (hi − lo) + 1 cycles.
- `done` is asserted in the cycle after the final RAMP_DN turn cycle. `busy` falls in the following cycle.
- `err` is asserted in the cycle after the rejected `start`.
- A `start` asserted while busy is ignored.
- A `start` asserted in the DONE cycle is ignored; the earliest accepted restart is the cycle after DONE.

## Test plan
- Single sweep: start=3, hi=6, lo=1, n=1.
  - Cycle 1: `load`=1, `IN`=3.
  - Cycles 2-4: `UP`=1. Cycle 5: idle turn. Cycles 6-10: `Down`=1. Cycle 11: turn.
  - Cycle 12: `done`=1, `sweep_cnt`=1. Cycle 13: `busy`=0.
- Three sweeps: start=0, hi=31, lo=0, n=3. The counter reaches 31 and 0 three times; never 32 or wrap. `done` fires once, with `sweep_cnt`=3.
- Rejects:
  - lo=5, hi=5 → `err` pulse, `busy` stays 0.
  - start_val=7, hi=6 → `err` pulse, `busy` stays 0.
- `pause` for 4 cycles mid RAMP_UP at value 4: `UP`=0 and `cnt_val` holds 4; the run resumes and the total length grows by exactly 4 cycles.
- Edge cases:
  - `abort` and `pause` asserted together in RAMP_DN → IDLE next cycle, no `done`, all commands 0.
  - n=0 → sweeps continue past `sweep_cnt`=15 (wraps) until `abort`.
- Async reset low mid RAMP_UP → all outputs 0 immediately. After release, `start` runs a full sweep normally.
